// File: rtl/instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer
//
// Owns the program counter and the single port of the instruction memory.
// The port is shared between a host program loader (writes over a
// valid/ready stream, always starting at word 0) and instruction fetch
// (combinational reads at the PC). The sequencer walks the core through
// IDLE -> LOAD -> IDLE -> RUN (-> HALT) and presents fetched words to the
// IF/ID pipeline register.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   When defined, fetching HALT_WORD in RUN (not stalled, no branch) moves
//   the sequencer to HALT with the PC parked on the halt word. When not
//   defined, no comparator exists and RUN is left only through reset.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   load_valid     : host presents a program word
//   load_ready     : word accepted this cycle (IDLE, LOAD, HALT)
//   load_data      : program word
//   load_last      : marks the final word of a load
//   start          : one-cycle pulse, begin execution at RESET_PC
//   stall          : hazard unit holds the PC
//   branch_taken   : redirect fetch to branch_target on the next edge
//   branch_target  : redirect byte address (low two bits ignored)
//   instruction    : combinational memory read data at mem_addr
//   mem_addr       : byte address to memory
//   mem_wdata      : write data (load_data)
//   mem_we         : write enable, captured by memory at the rising edge
//   pc             : current fetch address
//   pc_plus4       : pc + 4 wrapped to the memory span
//   fetch_valid    : instruction at pc is valid for IF/ID capture
//   state          : IDLE=0, LOAD=1, RUN=2, HALT=3
//   load_count     : words written by the most recent load
// -----------------------------------------------------------------------------
module instruction_fetch_sequencer #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [31:0]              load_data,
    input  logic                     load_last,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic [31:0]              instruction,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_we,
    output logic [31:0]              pc,
    output logic [31:0]              pc_plus4,
    output logic                     fetch_valid,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   load_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Byte-address mask for the memory span; every PC update goes through it
    // so the bits above the word index are always zero.
    localparam logic [31:0] PC_MASK   = 32'(DEPTH * 4 - 1);
    localparam logic [31:0] PC_START  = RESET_PC & PC_MASK;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   COUNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [31:0]        pc_q, pc_d;
    logic               handshake;
    logic               halt_hit;

    assign load_ready = (state_q != S_RUN);
    assign handshake  = load_valid & load_ready;
    assign pc_plus4   = (pc_q + 32'd4) & PC_MASK;

`ifdef FETCH_HALT_DETECT_EN
    // Only a word that IF/ID would actually capture can halt the core, and
    // a taken branch in the same cycle overrides it.
    assign halt_hit = (state_q == S_RUN) & fetch_valid &
                      (instruction == HALT_WORD) & ~branch_taken;
`else
    logic unused_halt_inputs;
    assign unused_halt_inputs = ^{instruction, HALT_WORD};
    assign halt_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            pc_q    <= PC_START;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = '0;             // write pointer is zero outside LOAD
        count_d = count_q;
        pc_d    = pc_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                // A load beats a simultaneous start; the start is dropped.
                if (handshake) begin
                    count_d = COUNT_ONE;
                    if (!load_last) begin
                        state_d = S_LOAD;
                        ptr_d   = ptr_q + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (start) begin
                    state_d = S_RUN;
                    pc_d    = PC_START;
                end
            end

            S_LOAD: begin
                ptr_d = ptr_q;
                if (handshake) begin
                    count_d = count_q + 1'b1;
                    if (load_last || (ptr_q == PTR_LAST)) begin
                        state_d = S_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (halt_hit) begin
                    state_d = S_HALT;     // PC stays on the halt word
                end else if (branch_taken) begin
                    pc_d = (branch_target & ~32'd3) & PC_MASK;
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we      = handshake;
        mem_wdata   = load_data;
        mem_addr    = {{(30 - PTR_W){1'b0}}, ptr_q, 2'b00};
        fetch_valid = 1'b0;
        if (state_q == S_RUN) begin
            mem_addr    = pc_q;
            fetch_valid = !stall;
        end
    end

    assign pc         = pc_q;
    assign state      = state_q;
    assign load_count = count_q;

endmodule
